// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the two-client multiplier scheduler.
// Latency, backpressure: none here; this package holds only types and constants.
package mul_sched_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_ACC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: A reg, B down-counter, P accumulator.
// Latency: one cycle per control strobe; no backpressure, fully controller-driven.
module mul_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lda,
  input  logic             ldb,
  input  logic             ldp,
  input  logic             clrp,
  input  logic             decb,
  output logic             eqz,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] a_r, b_r, p_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
    end else begin
      if (lda) a_r <= data_in;
      if (ldb)       b_r <= data_in;
      else if (decb) b_r <= b_r - 1'b1;
      if (clrp)      p_r <= '0;
      else if (ldp)  p_r <= p_r + a_r;
    end
  end

  assign eqz = (b_r == '0);
  assign y   = p_r;

endmodule

// File: rtl/mul_sched_rr_arb2.sv
// Two-way round-robin pick; combinational pick, last_gnt updated on upd.
// Latency 0 for pick; no backpressure, the caller decides when to commit.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic pick,
  output logic last_gnt
);

  // On a tie the client not served last wins; a lone request wins outright.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_gnt <= 1'b1;
    else if (upd) last_gnt <= pick;
  end

endmodule

// File: rtl/mul_sched.sv
// Round-robin two-client scheduler/sequencer for the shared multiplier datapath.
// Latency: grant edge to done = b+3 cycles; losing client's req is held pending, no other backpressure.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] dp_data,
  output logic             dp_lda,
  output logic             dp_ldb,
  output logic             dp_ldp,
  output logic             dp_clrp,
  output logic             dp_decb,
  input  logic             dp_eqz,
  input  logic [WIDTH-1:0] dp_y
);

  state_t state, state_nxt;
  logic   leave_idle;
  logic   pick;
  logic   g;

  assign leave_idle = (state == S_IDLE) && (req0 || req1);

  // The arbiter's last_gnt is committed on IDLE exit, so it doubles as the grant register.
  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .upd      (leave_idle),
    .pick     (pick),
    .last_gnt (g)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req0 || req1) state_nxt = S_LOADA;
      S_LOADA: state_nxt = S_LOADB;
      S_LOADB: state_nxt = S_ACC;
      S_ACC:   if (dp_eqz) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          result <= '0;
    else if ((state == S_ACC) && dp_eqz) result <= dp_y;
  end

  always_comb begin
    dp_data = '0;
    dp_lda  = 1'b0;
    dp_ldb  = 1'b0;
    dp_ldp  = 1'b0;
    dp_clrp = 1'b0;
    dp_decb = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    case (state)
      S_LOADA: begin
        dp_data = g ? a1 : a0;
        dp_lda  = 1'b1;
        dp_clrp = 1'b1;
      end
      S_LOADB: begin
        dp_data = g ? b1 : b0;
        dp_ldb  = 1'b1;
      end
      S_ACC: begin
        dp_ldp  = ~dp_eqz;
        dp_decb = ~dp_eqz;
      end
      S_DONE: begin
        done0 = ~g;
        done1 = g;
      end
      default: ;
    endcase
    busy = (state != S_IDLE);
    gnt0 = busy && !g;
    gnt1 = busy && g;
  end

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched + mul_datapath: table vectors, hand sequences and random client traffic
// checked cycle by cycle against a transaction-level model of grants, timing and products.
module tb_mul_sched;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] result, dp_data, dp_y;
  logic         dp_lda, dp_ldb, dp_ldp, dp_clrp, dp_decb, dp_eqz;

  always #5 clk = ~clk;

  mul_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .dp_data(dp_data),
    .dp_lda(dp_lda), .dp_ldb(dp_ldb), .dp_ldp(dp_ldp), .dp_clrp(dp_clrp), .dp_decb(dp_decb),
    .dp_eqz(dp_eqz), .dp_y(dp_y)
  );

  mul_datapath #(.WIDTH(W)) u_dp (
    .clk(clk), .rst_n(rst_n), .data_in(dp_data),
    .lda(dp_lda), .ldb(dp_ldb), .ldp(dp_ldp), .clrp(dp_clrp), .decb(dp_decb),
    .eqz(dp_eqz), .y(dp_y)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } job_t;

  typedef struct {
    bit           r0;
    bit           r1;
    logic [W-1:0] a0, b0, a1, b1;
    int           first;
    logic [W-1:0] e0, e1;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  job_t jq0[$], jq1[$];
  bit   w0, w1, drop_early0, drop_early1;
  int   start0, start1;
  int   served[$];
  logic [W-1:0] got0, got1;

  // Transaction-level reference: one operation at a time, b+3 edges grant->done, b+5 to next grant.
  bit           m_act;
  int           m_c, m_last, m_g, m_d, m_next_ok;
  logic [W-1:0] m_a, m_b, m_prod, m_res;

  function automatic logic [W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] f;
    f = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return f[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (cyc >= m_next_ok && (req0 || req1)) begin
      if (req0 && req1) m_c = (m_last == 1) ? 0 : 1;
      else              m_c = req1 ? 1 : 0;
      m_last    = m_c;
      m_act     = 1'b1;
      m_g       = cyc;
      m_a       = (m_c == 1) ? a1 : a0;
      m_b       = (m_c == 1) ? b1 : b0;
      m_prod    = prod(m_a, m_b);
      m_d       = cyc + int'(m_b) + 3;
      m_next_ok = m_d + 2;
    end
    if (m_act && cyc == m_d) m_res = m_prod;
  endtask

  task automatic check_cycle();
    bit in_op;
    logic [5:0] ev;
    in_op = m_act && cyc >= m_g && cyc <= m_d;
    ev = {in_op && m_c == 0, in_op && m_c == 1,
          m_act && cyc == m_d && m_c == 0, m_act && cyc == m_d && m_c == 1,
          in_op, m_act && cyc >= m_g + 2 && cyc <= m_d - 2};
    chk("ctl_gnt_done_busy_ldp", 64'({gnt0, gnt1, done0, done1, busy, dp_ldp}), 64'(ev));
    chk("result_reg", 64'(result), 64'(m_res));
    if (m_act && cyc == m_g)
      chk("loada", 64'({dp_lda, dp_clrp, dp_ldb, dp_data}), 64'({3'b110, m_a}));
    if (m_act && cyc == m_g + 1)
      chk("loadb", 64'({dp_lda, dp_ldb, dp_data}), 64'({2'b01, m_b}));
  endtask

  task automatic drive();
    if (w0) begin
      if (done0) begin
        chk("done_result0", 64'(result), 64'(prod(jq0[0].a, jq0[0].b)));
        got0 = result;
        served.push_back(0);
        void'(jq0.pop_front());
        w0 = 1'b0;
        req0 = 1'b0;
      end else if (drop_early0 && gnt0) req0 = 1'b0;
    end else if (jq0.size() > 0 && cyc >= start0) begin
      req0 = 1'b1; a0 = jq0[0].a; b0 = jq0[0].b; w0 = 1'b1;
    end
    if (w1) begin
      if (done1) begin
        chk("done_result1", 64'(result), 64'(prod(jq1[0].a, jq1[0].b)));
        got1 = result;
        served.push_back(1);
        void'(jq1.pop_front());
        w1 = 1'b0;
        req1 = 1'b0;
      end else if (drop_early1 && gnt1) req1 = 1'b0;
    end else if (jq1.size() > 0 && cyc >= start1) begin
      req1 = 1'b1; a1 = jq1[0].a; b1 = jq1[0].b; w1 = 1'b1;
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run(input int max_cyc, input int stop_after);
    drive();
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      check_cycle();
      drive();
      if (stop_after > 0 && k + 1 >= stop_after) return;
      if (jq0.size() == 0 && jq1.size() == 0 && !w0 && !w1 && cyc >= m_next_ok - 1) return;
    end
    checks++;
    failures++;
    $display("FAIL run_timeout: no completion within %0d cycles (cycle %0d)", max_cyc, cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
    jq0.delete(); jq1.delete();
    m_act = 1'b0; m_last = 1; m_res = '0; m_next_ok = 0;
    #1;
    chk("rst_ctl", 64'({gnt0, gnt1, done0, done1, busy, dp_lda, dp_ldb, dp_ldp, dp_clrp, dp_decb}), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_data", 64'(dp_data), 64'(0));
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_hold", 64'({done0, done1, busy, result}), 64'(0));
    end
    rst_n = 1'b1;
  endtask

  vec_t tv[4];

  initial begin
    int nj0, nj1;
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    drop_early0 = 1'b0; drop_early1 = 1'b0;
    start0 = 0; start1 = 0;
    tv[0] = '{r0: 1, r1: 1, a0: 3, b0: 4, a1: 6, b1: 2, first: 0, e0: 12, e1: 12};
    tv[1] = '{r0: 1, r1: 0, a0: 7, b0: 5, a1: 0, b1: 0, first: 0, e0: 35, e1: 0};
    tv[2] = '{r0: 1, r1: 0, a0: 32'hFFFF_FFFF, b0: 2, a1: 0, b1: 0, first: 0, e0: 32'hFFFF_FFFE, e1: 0};
    tv[3] = '{r0: 0, r1: 1, a0: 0, b0: 0, a1: 123, b1: 0, first: 1, e0: 0, e1: 0};
    #1;
    do_reset();

    for (int i = 0; i < 4; i++) begin
      served.delete();
      if (tv[i].r0) jq0.push_back('{tv[i].a0, tv[i].b0});
      if (tv[i].r1) jq1.push_back('{tv[i].a1, tv[i].b1});
      start0 = cyc; start1 = cyc;
      run(300, 0);
      chk("tv_first", 64'(served.size() > 0 ? served[0] : -1), 64'(tv[i].first));
      if (tv[i].r0) chk("tv_res0", 64'(got0), 64'(tv[i].e0));
      if (tv[i].r1) chk("tv_res1", 64'(got1), 64'(tv[i].e1));
    end

    // Client 1 served last: tie goes to 0, then 0 re-requests and ties with pending 1, which wins.
    served.delete();
    jq0.push_back('{32'd5, 32'd1});
    jq0.push_back('{32'd9, 32'd2});
    jq1.push_back('{32'd4, 32'd3});
    start0 = cyc; start1 = cyc;
    run(300, 0);
    chk("alt_count", 64'(served.size()), 64'(3));
    if (served.size() == 3)
      chk("alt_order", 64'(served[0] * 100 + served[1] * 10 + served[2]), 64'(10));
    chk("alt_res1", 64'(got1), 64'(12));
    chk("alt_res0", 64'(got0), 64'(18));

    // Reset mid-ACC, then a fresh operation must still be exact.
    served.delete();
    jq0.push_back('{32'd11, 32'd10});
    start0 = cyc;
    run(300, 5);
    chk("pre_rst_busy", 64'({busy, gnt0}), 64'(2'b11));
    do_reset();
    chk("rst_no_done", 64'(served.size()), 64'(0));
    jq0.push_back('{32'd2, 32'd3});
    start0 = cyc;
    run(300, 0);
    chk("post_rst_res", 64'(got0), 64'(6));

    for (int it = 0; it < 40; it++) begin
      served.delete();
      nj0 = $urandom_range(0, 2);
      nj1 = $urandom_range(0, 2);
      if (nj0 == 0 && nj1 == 0) nj0 = 1;
      for (int j = 0; j < nj0; j++) jq0.push_back('{$urandom(), 32'($urandom_range(0, 12))});
      for (int j = 0; j < nj1; j++) jq1.push_back('{$urandom(), 32'($urandom_range(0, 12))});
      start0 = cyc + $urandom_range(0, 4);
      start1 = cyc + $urandom_range(0, 4);
      drop_early0 = 1'($urandom_range(0, 1));
      drop_early1 = 1'($urandom_range(0, 1));
      run(400, 0);
      chk("rnd_served", 64'(served.size()), 64'(nj0 + nj1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_sched.md
# mul_sched

Two-requester scheduler and sequencer for the shared repeated-addition multiplier datapath (mul_datapath). It arbitrates round-robin between two clients and steers the winner's operands onto the shared data_in bus. It drives LdA/LdB/LdP/clrP/decB from the eqz flag and returns the product with a one-cycle done pulse to the granted client. It replaces the free-running controller and fixes the iteration count so the product is exactly a*b, including b=0.

## Interface
- WIDTH, 32, operand/product width; must match datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  level request from client 0 / 1
- a0, b0 / a1, b1  in  WIDTH  client operands; held stable while req is high until done
- gnt0 / gnt1  out  1  high from LOADA through DONE for the granted client
- done0 / done1  out  1  one-cycle completion pulse to the granted client
- result  out  WIDTH  registered product; valid in the done cycle, held until next capture
- busy  out  1  high in any state other than IDLE
- dp_data  out  WIDTH  to datapath data_in
- dp_lda, dp_ldb, dp_ldp, dp_clrp, dp_decb  out  1  datapath controls
- dp_eqz  in  1  datapath counter-is-zero flag
- dp_y  in  WIDTH  datapath product register

## Operation
- FSM states: IDLE, LOADA, LOADB, ACC, DONE. Outputs are Moore-decoded from state and the grant register.
- IDLE:
  - All dp controls are 0 and dp_data is 0.
  - If any req is high at the clock edge, latch the grant and go to LOADA.
- Arbitration:
  - A single request wins outright.
  - When both requests are high, the winner is the client not served last (last_gnt).
  - After reset, last_gnt = 1, so client 0 wins the first tie.
  - last_gnt updates when IDLE is left.
- LOADA: dp_data = a_g, dp_lda = 1, dp_clrp = 1; then LOADB.
- LOADB: dp_data = b_g, dp_ldb = 1; then ACC.
- ACC:
  - If dp_eqz = 0: dp_ldp = 1, dp_decb = 1, stay in ACC.
  - If dp_eqz = 1: all controls 0, capture result <= dp_y, go to DONE.
- DONE: done_g = 1 for this cycle only; then IDLE.
- Arithmetic: result = (a*b) mod 2^WIDTH, with exactly b accumulations. For b = 0 the result is 0.
- Client rule: deassert req on the edge where done is sampled high; new operands need a fresh req in a later cycle.
- Controller behaviour vs. client req:
  - Dropping req mid-operation is ignored; the operation completes and done still pulses.
  - req on the non-granted client is held pending and served after DONE→IDLE.
- Reset (asynchronous, any state): state = IDLE, last_gnt = 1, result = 0. All outputs go to 0 immediately. The datapath is reinitialised by the next LOADA, since clrP clears P.

## Timing
- Grant edge (IDLE→LOADA) to done pulse: b+3 cycles. Occupancy is 1 LOADA + 1 LOADB + (b+1) ACC + 1 DONE = b+4 cycles.
- dp_eqz is sampled in ACC only; it reflects the counter value loaded or decremented on the previous edge.
- Back-to-back requests: at least one IDLE cycle separates DONE from the next LOADA.
- Minimum operation (b=0): LOADA, LOADB, ACC (eqz=1), DONE = 4 cycles.
- result changes only on the ACC→DONE edge.
- gnt and done are never both high for different clients.

## Structure
- Package mul_sched_pkg:
  - state encoding constants (3-bit: IDLE=0, LOADA=1, LOADB=2, ACC=3, DONE=4)
  - default WIDTH
- Sub-module rr_arb2: combinational two-way round-robin pick from (req0, req1, last_gnt), with a separate registered last_gnt update.
- Top contains the FSM, operand mux, result register and output decode.
- Bench instantiates mul_sched with mul_datapath.

## Test plan
- req0 only, a0=7, b0=5 → done0 at grant+8 cycles, result=35, dp_ldp high for exactly 5 cycles.
- req1 only, a1=123, b1=0 → done1 at grant+3, result=0, dp_ldp never asserted.
- req0 and req1 high in the same cycle from reset (a0=3,b0=4; a1=6,b1=2) → client 0 first (result 12), one IDLE cycle, then client 1 (result 12).
- Second simultaneous pair after client 1 was last served → client 0 wins; then a third pair → client 1 wins (alternation).
- a0=0xFFFF_FFFF, b0=2 → result=0xFFFF_FFFE (wrap mod 2^32).
- rst_n pulsed low mid-ACC with b0=10 → outputs 0 and busy=0 immediately with no done pulse; re-request a0=2,b0=3 → result=6.
